// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
//
// Command sequencer between the UART byte paths and the shared ALU.
// It assembles a six-byte frame (HEADER, A lo, A hi, B lo, B hi, FUN) from the
// RX stream. It then loads the ALU operand/function registers and pulses
// ALU_EN for one cycle. Next it waits a bounded time for ALU_valid, captures
// the result, and streams it LSB first over a valid/ready TX handshake.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   RX_data    in   received byte
//   RX_valid   in   one-cycle strobe qualifying RX_data
//   ALU_A      out  operand A (registered, holds between commands)
//   ALU_B      out  operand B (registered, holds between commands)
//   ALU_FUN    out  function code (registered, holds between commands)
//   ALU_EN     out  one-cycle ALU enable
//   ALU_out    in   ALU result
//   ALU_valid  in   ALU result valid
//   TX_data    out  result byte to transmitter
//   TX_valid   out  TX_data valid
//   TX_ready   in   transmitter accepts byte when TX_valid && TX_ready
//   Busy       out  high whenever the sequencer is not idle
//   Err        out  one-cycle error pulse
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           OP_WIDTH   = 16,
    parameter int unsigned           OUT_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] HEADER     = 8'hCC,
    parameter int unsigned           TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] RX_data,
    input  logic                  RX_valid,
    output logic [OP_WIDTH-1:0]   ALU_A,
    output logic [OP_WIDTH-1:0]   ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_out,
    input  logic                  ALU_valid,
    output logic [DATA_WIDTH-1:0] TX_data,
    output logic                  TX_valid,
    input  logic                  TX_ready,
    output logic                  Busy,
    output logic                  Err
);

    // State encoding
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] GET_AL   = 4'd1;
    localparam logic [3:0] GET_AH   = 4'd2;
    localparam logic [3:0] GET_BL   = 4'd3;
    localparam logic [3:0] GET_BH   = 4'd4;
    localparam logic [3:0] GET_FUN  = 4'd5;
    localparam logic [3:0] EXEC     = 4'd6;
    localparam logic [3:0] WAIT_RES = 4'd7;
    localparam logic [3:0] SEND     = 4'd8;

    localparam int unsigned NUM_BYTES = OUT_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Reset synchronizer: assertion is immediate, release is aligned to CLK.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // State and registered outputs
    logic [3:0]            state_q,    state_d;
    logic [OP_WIDTH-1:0]   alu_a_q,    alu_a_d;
    logic [OP_WIDTH-1:0]   alu_b_q,    alu_b_d;
    logic [3:0]            alu_fun_q,  alu_fun_d;
    logic                  alu_en_q,   alu_en_d;
    logic [OUT_WIDTH-1:0]  result_q,   result_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q,     busy_d;
    logic                  err_q,      err_d;

    // Byte view of the captured result, LSB byte at index 0
    logic [DATA_WIDTH-1:0] res_bytes [NUM_BYTES];

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_res_bytes
        assign res_bytes[i] = result_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        alu_en_d   = 1'b0;
        result_d   = result_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-header bytes are noise between frames, not errors.
                if (RX_valid && (RX_data == HEADER)) begin
                    state_d = GET_AL;
                end
            end
            GET_AL: begin
                if (RX_valid) begin
                    alu_a_d[DATA_WIDTH-1:0] = RX_data;
                    state_d                 = GET_AH;
                end
            end
            GET_AH: begin
                if (RX_valid) begin
                    alu_a_d[OP_WIDTH-1:DATA_WIDTH] = RX_data;
                    state_d                        = GET_BL;
                end
            end
            GET_BL: begin
                if (RX_valid) begin
                    alu_b_d[DATA_WIDTH-1:0] = RX_data;
                    state_d                 = GET_BH;
                end
            end
            GET_BH: begin
                if (RX_valid) begin
                    alu_b_d[OP_WIDTH-1:DATA_WIDTH] = RX_data;
                    state_d                        = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_valid) begin
                    if (RX_data[DATA_WIDTH-1:4] == '0) begin
                        alu_fun_d = RX_data[3:0];
                        alu_en_d  = 1'b1;  // high for exactly the EXEC cycle
                        state_d   = EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            EXEC: begin
                if (RX_valid) begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (RX_valid) begin
                    err_d = 1'b1;
                end
                if (ALU_valid) begin
                    result_d   = ALU_out;
                    tx_data_d  = ALU_out[DATA_WIDTH-1:0];
                    tx_valid_d = 1'b1;
                    idx_d      = '0;
                    state_d    = SEND;
                end else if (cnt_q == CNT_LAST) begin
                    // Err lands on the cycle the count reaches TIMEOUT.
                    err_d   = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (RX_valid) begin
                    err_d = 1'b1;
                end
                // TX_valid is always high in SEND, so TX_ready alone completes a beat.
                if (TX_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = res_bytes[idx_d];
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            result_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign ALU_FUN  = alu_fun_q;
    assign ALU_EN   = alu_en_q;
    assign TX_data  = tx_data_q;
    assign TX_valid = tx_valid_q;
    assign Busy     = busy_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_ctrl
//
// Self-checking bench for alu_cmd_ctrl. A small registered ALU stand-in answers
// ALU_EN one cycle later. Expected TX bytes come from plain arithmetic on the
// operands the bench itself put into each frame.
// -----------------------------------------------------------------------------
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  RX_data;
    logic        RX_valid;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [31:0] ALU_out;
    logic        ALU_valid;
    logic [7:0]  TX_data;
    logic        TX_valid;
    logic        TX_ready;
    logic        Busy;
    logic        Err;

    int          n_pass    = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          en_count  = 0;
    int          err_count = 0;
    logic        alu_stall = 1'b0;
    logic [3:0]  last_fun  = 4'h0;

    alu_cmd_ctrl dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .RX_data   (RX_data),
        .RX_valid  (RX_valid),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_FUN   (ALU_FUN),
        .ALU_EN    (ALU_EN),
        .ALU_out   (ALU_out),
        .ALU_valid (ALU_valid),
        .TX_data   (TX_data),
        .TX_valid  (TX_valid),
        .TX_ready  (TX_ready),
        .Busy      (Busy),
        .Err       (Err)
    );

    always #5 CLK = ~CLK;

    // Bench-side ALU semantics
    function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        logic [31:0] xa;
        logic [31:0] xb;
        xa = {16'h0, a};
        xb = {16'h0, b};
        case (f)
            4'd0:    return xa + xb;
            4'd1:    return xa - xb;
            4'd2:    return xa * xb;
            4'd3:    return (b == 16'h0) ? 32'h0 : xa / xb;
            4'd4:    return xa & xb;
            4'd5:    return xa | xb;
            4'd6:    return xa ^ xb;
            4'd7:    return {a, b};
            default: return {b, a} ^ {28'h0, f};
        endcase
    endfunction

    // Registered ALU stand-in; alu_stall suppresses its valid for the timeout test.
    always @(posedge CLK) begin
        ALU_valid <= ALU_EN && !alu_stall;
        if (ALU_EN) begin
            ALU_out <= alu_ref(ALU_A, ALU_B, ALU_FUN);
        end
        if (ALU_EN) begin
            en_count <= en_count + 1;
        end
        if (Err) begin
            err_count <= err_count + 1;
        end
    end

    initial begin
        ALU_valid = 1'b0;
        ALU_out   = 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_data  = b;
        RX_valid = 1'b1;
        @(negedge CLK);
        RX_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] fb);
        send_byte(8'hCC);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte(fb);
    endtask

    // mode: 0 = TX_ready always high, 1 = ready one cycle in three, 2 = random ready
    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] f, input int mode, input bit overrun);
        logic [31:0] exp;
        logic [7:0]  got [4];
        logic [7:0]  held;
        int          n;
        int          cyc;
        int          en0;
        int          err0;
        bit          rdy;
        bit          stalled;

        exp     = alu_ref(a, b, f);
        en0     = en_count;
        err0    = err_count;
        n       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 8'h0;
        for (int i = 0; i < 4; i++) got[i] = 8'hxx;

        send_frame(a, b, {4'h0, f});
        // Now in the cycle right after the FUN byte was sampled.
        check({tag, "_alu_en_pulse"}, 32'(ALU_EN), 32'd1);
        check({tag, "_alu_a"},        32'(ALU_A),  32'(a));
        check({tag, "_alu_b"},        32'(ALU_B),  32'(b));
        check({tag, "_alu_fun"},      32'(ALU_FUN), 32'(f));
        check({tag, "_busy"},         32'(Busy),   32'd1);
        last_fun = f;
        @(negedge CLK);
        check({tag, "_alu_en_low"},   32'(ALU_EN), 32'd0);
        @(negedge CLK);
        check({tag, "_tx_latency"},   32'(TX_valid), 32'd1);

        while (n < 4 && cyc < 64) begin
            check({tag, "_tx_valid_held"}, 32'(TX_valid), 32'd1);
            if (TX_valid !== 1'b1) break;
            if (stalled) check({tag, "_tx_stable"}, 32'(TX_data), 32'(held));
            if (overrun && cyc == 2) check({tag, "_overrun_err"}, 32'(Err), 32'd1);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            TX_ready = rdy;
            if (overrun && cyc == 1) begin
                RX_data  = 8'hCC;
                RX_valid = 1'b1;
            end else begin
                RX_valid = 1'b0;
            end
            if (rdy) begin
                got[n] = TX_data;
                n++;
            end
            stalled = !rdy;
            held    = TX_data;
            @(negedge CLK);
            cyc++;
        end
        TX_ready = 1'b0;
        RX_valid = 1'b0;

        check({tag, "_byte_count"}, 32'(n), 32'd4);
        if (mode == 0) check({tag, "_b2b_cycles"}, 32'(cyc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[8*i +: 8]));
        end
        check({tag, "_tx_valid_done"}, 32'(TX_valid), 32'd0);
        check({tag, "_busy_done"},     32'(Busy),     32'd0);
        check({tag, "_en_pulses"},     32'(en_count - en0), 32'd1);
        check({tag, "_err_pulses"},    32'(err_count - err0), overrun ? 32'd1 : 32'd0);
    endtask

    initial begin : stimulus
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rf;
        logic [31:0] rexp;
        int          err0;
        int          en0;

        Reset    = 1'b0;
        RX_valid = 1'b0;
        RX_data  = 8'h00;
        TX_ready = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset values
        check("rst_alu_a",    32'(ALU_A),    32'd0);
        check("rst_alu_b",    32'(ALU_B),    32'd0);
        check("rst_alu_fun",  32'(ALU_FUN),  32'd0);
        check("rst_alu_en",   32'(ALU_EN),   32'd0);
        check("rst_tx_data",  32'(TX_data),  32'd0);
        check("rst_tx_valid", 32'(TX_valid), 32'd0);
        check("rst_busy",     32'(Busy),     32'd0);
        check("rst_err",      32'(Err),      32'd0);

        Reset = 1'b1;
        repeat (3) @(negedge CLK);

        // Add, ready held high
        run_frame("add", 16'd11, 16'd300, 4'd0, 0, 1'b0);

        // Multiply with backpressure
        run_frame("mul", 16'd2222, 16'd2222, 4'd2, 1, 1'b0);

        // Noise bytes in IDLE are ignored silently
        err0 = err_count;
        send_byte(8'h55);
        check("noise55_busy", 32'(Busy), 32'd0);
        send_byte(8'h12);
        check("noise12_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        check("noise_err", 32'(err_count - err0), 32'd0);
        run_frame("div", 16'd1, 16'd2, 4'd3, 0, 1'b0);

        // Bad function byte
        err0 = err_count;
        en0  = en_count;
        send_frame(16'd5, 16'd3, 8'h13);
        check("badfun_err",     32'(Err),     32'd1);
        check("badfun_alu_en",  32'(ALU_EN),  32'd0);
        check("badfun_fun",     32'(ALU_FUN), 32'(last_fun));
        check("badfun_alu_a",   32'(ALU_A),   32'd5);
        check("badfun_busy",    32'(Busy),    32'd0);
        @(negedge CLK);
        check("badfun_err_one", 32'(Err),     32'd0);
        check("badfun_pulses",  32'(err_count - err0), 32'd1);
        check("badfun_no_en",   32'(en_count - en0),   32'd0);

        // ALU never answers: Err on the 8th cycle after entering WAIT_RES
        alu_stall = 1'b1;
        send_frame(16'd7, 16'd9, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            check($sformatf("timeout_err_k%0d", k), 32'(Err), (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("timeout_txv_k%0d", k), 32'(TX_valid), 32'd0);
            if (k == 10) check("timeout_busy", 32'(Busy), 32'd0);
        end
        alu_stall = 1'b0;

        // Overrun byte during SEND
        run_frame("overrun", 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 0, 1'b1);

        // Reset after two TX bytes
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rexp = alu_ref(ra, rb, 4'd0);
        send_frame(ra, rb, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        check("rstmid_first_byte", 32'(TX_data), 32'(rexp[7:0]));
        TX_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        TX_ready = 1'b0;
        check("rstmid_third_byte", 32'(TX_data), 32'(rexp[23:16]));
        #2 Reset = 1'b0;
        #1;
        check("rstmid_tx_valid", 32'(TX_valid), 32'd0);
        check("rstmid_tx_data",  32'(TX_data),  32'd0);
        check("rstmid_busy",     32'(Busy),     32'd0);
        check("rstmid_alu_a",    32'(ALU_A),    32'd0);
        check("rstmid_alu_b",    32'(ALU_B),    32'd0);
        check("rstmid_err",      32'(Err),      32'd0);
        last_fun = 4'h0;
        @(negedge CLK);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("rstmid_idle", 32'(Busy), 32'd0);
        run_frame("post_reset", 16'($urandom), 16'($urandom), 4'd1, 0, 1'b0);

        // Random frames, random backpressure
        for (int t = 0; t < 8; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 4'($urandom_range(0, 15));
            run_frame($sformatf("rand%0d", t), ra, rb, rf, 2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command sequencer that sits between the UART receive/transmit byte paths and the shared ALU. It assembles a 6-byte command frame from the RX byte stream, loads operands and function into the ALU and pulses its enable. It then captures the 32-bit result and returns it as four bytes over a valid/ready TX handshake. It is the only block that drives the ALU's enable, operand and function inputs.

## Interface
- DATA_WIDTH, 8: RX/TX byte width
- OP_WIDTH, 16: ALU operand width (two bytes each)
- OUT_WIDTH, 32: ALU result width (four bytes)
- HEADER, 8'hCC: frame start byte
- TIMEOUT, 8: cycles to wait for ALU valid before aborting
- CLK  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- RX_data  in  8  received byte
- RX_valid  in  1  one-cycle strobe, RX_data valid
- ALU_A  out  16  operand A to ALU
- ALU_B  out  16  operand B to ALU
- ALU_FUN  out  4  function code to ALU
- ALU_EN  out  1  one-cycle ALU enable
- ALU_out  in  32  ALU result
- ALU_valid  in  1  ALU Out_valid
- TX_data  out  8  result byte to transmitter
- TX_valid  out  1  TX_data valid
- TX_ready  in  1  transmitter accepts byte when TX_valid && TX_ready
- Busy  out  1  high in every state except IDLE
- Err  out  1  one-cycle error pulse

## Operation
- Frame: HEADER, A[7:0], A[15:8], B[7:0], B[15:8], FUN byte (bits [3:0] = ALU_FUN, bits [7:4] must be 0).
- States: IDLE, GET_AL, GET_AH, GET_BL, GET_BH, GET_FUN, EXEC, WAIT_RES, SEND.
- IDLE: RX_valid with RX_data == HEADER -> GET_AL. Any other byte is silently ignored; no Err.
- GET_* states advance one state per RX_valid and write the byte directly into the ALU_A/ALU_B register slice.
- GET_FUN, upper nibble 0: load ALU_FUN -> EXEC. Upper nibble nonzero: Err pulse -> IDLE, ALU_FUN unchanged, no ALU_EN.
- All function codes 0..15 are forwarded; the controller does not interpret them.
- EXEC: ALU_EN = 1 for exactly this cycle -> WAIT_RES, timeout counter cleared.
- WAIT_RES: on the first cycle with ALU_valid = 1, capture ALU_out into the result register -> SEND, byte index 0.
- WAIT_RES timeout: if ALU_valid is not seen within TIMEOUT cycles of entering WAIT_RES, Err pulse -> IDLE, no TX.
- SEND: TX_valid = 1, TX_data = result byte[index], LSB first. On TX_valid && TX_ready the index increments. Handshake on index 3 -> IDLE.
- TX_data must stay stable while TX_valid && !TX_ready.
- RX_valid in EXEC, WAIT_RES or SEND: byte dropped, Err pulse. A frame is not restarted mid-flight.
- ALU_A, ALU_B and ALU_FUN hold their last loaded values between commands.

## Timing
- Reset (asynchronous assert, synchronous release) sets: state IDLE; ALU_A, ALU_B, ALU_FUN, TX_data, result register = 0; ALU_EN, TX_valid, Busy, Err = 0.
- All outputs are registered.
- FUN byte sampled at edge N: ALU_EN high in cycle N..N+1 (one cycle).
- ALU registers its output at edge N+1, so ALU_valid is seen in cycle N+1..N+2. The result is captured at edge N+2, and TX_valid rises in cycle N+2..N+3.
- Minimum frame-end to first TX byte: 3 cycles. Back-to-back TX with TX_ready held high: 4 consecutive cycles.
- Err is a single-cycle pulse. Two error conditions in one cycle still produce one pulse.
- Timeout counter width is clog2(TIMEOUT+1). Err is asserted on the cycle the count reaches TIMEOUT.
- Reset mid-frame or mid-SEND: immediate return to IDLE. No partial byte is completed, and TX_valid drops asynchronously.

## Test plan
- Add: frame CC 0B 00 2C 01 00 (11 + 300), TX_ready = 1 -> one ALU_EN pulse, ALU_A = 11, ALU_B = 300; TX bytes 37 01 00 00, Busy low after the 4th byte.
- Multiply with backpressure: frame CC AE 08 AE 08 02 (2222 × 2222), TX_ready toggled 1-of-3 cycles -> TX bytes 44 56 4B 00 (4937284); TX_data stable while stalled.
- Framing: bytes 55 12 then CC 01 00 02 00 03 -> 55 and 12 ignored with no Err and Busy low; the valid frame returns 00 00 00 00 (1/2).
- Bad function: frame CC 05 00 03 00 13 -> Err one cycle, no ALU_EN, ALU_FUN keeps its prior value, back to IDLE.
- Timeout: valid add frame with ALU_valid forced 0 -> Err exactly TIMEOUT = 8 cycles after entering WAIT_RES, no TX_valid, Busy low next cycle.
- Overrun and reset: RX byte during SEND -> Err pulse, TX sequence unaffected. Reset asserted after the 2nd TX byte -> all outputs 0 immediately, and the next full frame completes normally.
